// File: rtl/fir_coeff_loader.sv
// Double-buffered FIR coefficient store: streams a coefficient set into the shadow bank and
// swaps it in only at a filter sample boundary, so a filter pass never mixes two sets.
module fir_coeff_loader #(
    parameter int unsigned COEFF_W  = 24,
    parameter int unsigned NUM_TAPS = 100,
    parameter int unsigned ADDR_W   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_start,
    input  logic               cfg_valid,
    input  logic [COEFF_W-1:0] cfg_data,
    input  logic               cfg_last,
    output logic               cfg_ready,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [COEFF_W-1:0] rd_data,
    input  logic               swap_ok,
    output logic               active_bank,
    output logic               busy,
    output logic               load_done,
    output logic               load_error
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWaitSwap
    } state_e;

    localparam logic [ADDR_W-1:0] LastTap = ADDR_W'(NUM_TAPS - 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic               active_q, active_d;
    logic               ready_q;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [COEFF_W-1:0] rd_data_q;
    logic [COEFF_W-1:0] mem [2][NUM_TAPS];
    logic               accept;

    assign accept = cfg_valid && ready_q;

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        active_d = active_q;
        done_d   = 1'b0;
        error_d  = error_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    state_d  = StLoad;
                    wr_cnt_d = '0;
                    error_d  = 1'b0;
                end
            end
            StLoad: begin
                if (accept) begin
                    if (wr_cnt_q == LastTap) begin
                        // Counter wraps instead of overrunning the tap range.
                        wr_cnt_d = '0;
                        if (cfg_last) begin
                            state_d = StWaitSwap;
                        end else begin
                            error_d = 1'b1;
                            state_d = StIdle;
                        end
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                        if (cfg_last) begin
                            error_d = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
            end
            StWaitSwap: begin
                if (swap_ok) begin
                    active_d = ~active_q;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            wr_cnt_q <= '0;
            active_q <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            active_q <= active_d;
            ready_q  <= (state_d == StLoad);
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    // Bank RAM is deliberately left out of reset; writes always target the shadow bank.
    always_ff @(posedge clk) begin
        if (reset && accept) begin
            mem[~active_q][wr_cnt_q] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else if (rd_addr <= LastTap) begin
            rd_data_q <= mem[active_q][rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign cfg_ready   = ready_q;
    assign rd_data     = rd_data_q;
    assign active_bank = active_q;
    assign busy        = (state_q != StIdle);
    assign load_done   = done_q;
    assign load_error  = error_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader with a bank model and a read-data scoreboard.
`timescale 1ns/1ps
module tb_fir_coeff_loader;

    localparam int NT = 100;

    logic        clk;
    logic        reset;
    logic        cfg_start;
    logic        cfg_valid;
    logic [23:0] cfg_data;
    logic        cfg_last;
    logic        cfg_ready;
    logic [6:0]  rd_addr;
    logic [23:0] rd_data;
    logic        swap_ok;
    logic        active_bank;
    logic        busy;
    logic        load_done;
    logic        load_error;

    fir_coeff_loader #(
        .COEFF_W (24),
        .NUM_TAPS(100),
        .ADDR_W  (7)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_start  (cfg_start),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_last   (cfg_last),
        .cfg_ready  (cfg_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .swap_ok    (swap_ok),
        .active_bank(active_bank),
        .busy       (busy),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [23:0] model_mem [2][NT];
    logic        model_active = 1'b0;
    logic [23:0] stim [128];
    logic [23:0] sb [$];
    bit          probe_en = 1'b0;
    int          hs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock; when probing, the expected read is queued from the pre-edge model.
    task automatic step();
        logic [23:0] e;
        if (probe_en) begin
            sb.push_back((int'(rd_addr) < NT) ? model_mem[model_active][rd_addr] : 24'h0);
        end
        tick();
        if (probe_en) begin
            e = sb.pop_front();
            check("rd_data", 32'(rd_data), 32'(e));
        end
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check("start_ready", 32'(cfg_ready), 1);
        check("start_busy", 32'(busy), 1);
        check("start_err_clr", 32'(load_error), 0);
    endtask

    task automatic stream(input int n, input int last_at, input bit gaps, output int nhs);
        int  k   = 0;
        int  cyc = 0;
        bit  acc;
        nhs = 0;
        while (k < n && cyc < 2000) begin
            cfg_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            cfg_data  = stim[k];
            cfg_last  = (k == last_at);
            acc = cfg_valid && cfg_ready;
            if (acc) model_mem[~model_active][k] = stim[k];
            step();
            if (acc) begin
                k++;
                nhs++;
            end
            cyc++;
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        check("stream_bound", 32'(cyc < 2000), 1);
    endtask

    task automatic do_swap(input int hold);
        swap_ok = 1'b0;
        repeat (hold) begin
            step();
            check("wait_busy", 32'(busy), 1);
            check("wait_bank", 32'(active_bank), 32'(model_active));
            check("wait_ready", 32'(cfg_ready), 0);
        end
        swap_ok = 1'b1;
        step();
        model_active = ~model_active;
        swap_ok = 1'b0;
        check("swap_bank", 32'(active_bank), 32'(model_active));
        check("swap_done", 32'(load_done), 1);
        check("swap_busy", 32'(busy), 0);
        step();
        check("done_pulse", 32'(load_done), 0);
    endtask

    initial begin
        reset     = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        cfg_last  = 1'b0;
        rd_addr   = '0;
        swap_ok   = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(cfg_ready), 0);
        check("rst_bank", 32'(active_bank), 0);
        check("rst_done", 32'(load_done), 0);
        check("rst_err", 32'(load_error), 0);
        check("rst_rd", 32'(rd_data), 0);
        reset = 1'b1;

        // Test 1: first set k+1; start with valid in idle must not be accepted
        for (int k = 0; k < NT; k++) stim[k] = 24'(k + 1);
        cfg_valid = 1'b1;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        check("start_ready", 32'(cfg_ready), 1);
        stream(NT, NT - 1, 1'b0, hs);
        check("t1_hs", 32'(hs), 100);
        check("t1_waitstate", 32'(busy), 1);
        do_swap(3);
        check("t1_bank1", 32'(active_bank), 1);
        probe_en = 1'b1;
        rd_addr  = 7'd5;
        sb.push_back(24'd6);
        tick();
        check("t1_rd5", 32'(rd_data), 32'(sb.pop_front()));

        // Test 2: all -1 into bank 0 while reads of tap 5 keep returning 6
        for (int k = 0; k < NT; k++) stim[k] = 24'hFFFFFF;
        start_load();
        stream(NT, NT - 1, 1'b0, hs);
        do_swap(2);
        step();
        check("t2_rd_neg1", 32'(rd_data), 32'hFFFFFF);
        check("t2_bank0", 32'(active_bank), 0);

        // Test 3: short set ends with an error and no swap
        for (int k = 0; k < NT; k++) stim[k] = 24'(24'h800000 + k);
        start_load();
        stream(51, 50, 1'b0, hs);
        check("t3_err", 32'(load_error), 1);
        check("t3_ready", 32'(cfg_ready), 0);
        check("t3_busy", 32'(busy), 0);
        check("t3_done", 32'(load_done), 0);
        swap_ok = 1'b1;
        repeat (3) step();
        swap_ok = 1'b0;
        check("t3_bank", 32'(active_bank), 0);
        check("t3_nodone", 32'(load_done), 0);

        // Test 4: long set; a 101st word finds the loader idle
        start_load();
        stream(NT, -1, 1'b0, hs);
        check("t4_hs", 32'(hs), 100);
        check("t4_err", 32'(load_error), 1);
        check("t4_busy", 32'(busy), 0);
        check("t4_ready", 32'(cfg_ready), 0);
        cfg_valid = 1'b1;
        check("t4_101_ready", 32'(cfg_ready), 0);
        step();
        cfg_valid = 1'b0;
        check("t4_err_hold", 32'(load_error), 1);
        check("t4_bank", 32'(active_bank), 0);

        // Test 5: random data with valid gaps, then full readback
        for (int k = 0; k < NT; k++) stim[k] = 24'($urandom);
        start_load();
        stream(NT, NT - 1, 1'b1, hs);
        check("t5_hs", 32'(hs), 100);
        do_swap(0);
        for (int a = 0; a < NT; a++) begin
            rd_addr = 7'(a);
            step();
        end
        rd_addr = 7'd100;
        step();
        check("t5_rd100", 32'(rd_data), 0);
        rd_addr = 7'd127;
        step();
        check("t5_rd127", 32'(rd_data), 0);

        // Test 6: reset on word 40 abandons the load
        for (int k = 0; k < NT; k++) stim[k] = 24'(k * 3 + 7);
        rd_addr = 7'd5;
        start_load();
        stream(40, -1, 1'b0, hs);
        probe_en  = 1'b0;
        reset     = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = stim[40];
        swap_ok   = 1'b1;
        step();
        reset     = 1'b1;
        cfg_valid = 1'b0;
        model_active = 1'b0;
        check("t6_busy", 32'(busy), 0);
        check("t6_ready", 32'(cfg_ready), 0);
        check("t6_bank", 32'(active_bank), 0);
        check("t6_err", 32'(load_error), 0);
        check("t6_rd", 32'(rd_data), 0);
        probe_en = 1'b1;
        repeat (3) begin
            step();
            check("t6_noswap", 32'(active_bank), 0);
            check("t6_nodone", 32'(load_done), 0);
        end
        swap_ok = 1'b0;
        rd_addr = 7'd40;
        step();
        rd_addr = 7'd39;
        step();
        check("sb_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
Writer side of the FIR coefficient memory. Accepts a streamed coefficient set over a valid/ready interface and stores it in a shadow bank. The FIR filter reads coefficients by tap index from the active bank. The two banks swap only when the filter signals a sample boundary, so a filter pass never sees a mix of old and new coefficients.

Parameters:
COEFF_W, 24, coefficient width in bits (signed two's complement)
NUM_TAPS, 100, number of coefficients per set
ADDR_W, 7, tap index width; must satisfy 2^ADDR_W >= NUM_TAPS

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
cfg_start  input  1  one-cycle pulse that begins a new coefficient load
cfg_valid  input  1  cfg_data is valid this cycle
cfg_data  input  COEFF_W  signed coefficient word; tap 0 first
cfg_last  input  1  marks the final word of the set; qualified by cfg_valid
cfg_ready  output  1  loader will accept a word this cycle
rd_addr  input  ADDR_W  tap index from the filter
rd_data  output  COEFF_W  signed coefficient from the active bank; registered
swap_ok  input  1  filter is at a sample boundary and a bank swap is safe
active_bank  output  1  bank currently driving rd_data
busy  output  1  state is not IDLE
load_done  output  1  one-cycle pulse on the cycle after a swap edge
load_error  output  1  sticky flag for a malformed load

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, wr_cnt=0, active_bank=0.
  - cfg_ready=0, busy=0, load_done=0, load_error=0, rd_data=0.
  - Bank RAM contents are not cleared.
  - Reset mid-load abandons the load with no swap. active_bank returns to 0.
- Storage: two banks of NUM_TAPS x COEFF_W. The shadow bank is !active_bank.
- State machine:
  - IDLE: cfg_ready=0. On cfg_start go to LOAD, clear wr_cnt, clear load_error. cfg_valid is ignored in IDLE.
  - LOAD: cfg_ready=1. A word is accepted when cfg_valid && cfg_ready.
    - An accepted word writes shadow[wr_cnt]=cfg_data, then wr_cnt increments.
    - cfg_last on word wr_cnt==NUM_TAPS-1: go to WAIT_SWAP.
    - cfg_last on word wr_cnt<NUM_TAPS-1 (short set): set load_error=1, go to IDLE.
    - Word at wr_cnt==NUM_TAPS-1 without cfg_last (long set): set load_error=1, go to IDLE. That word is written but never made active.
    - cfg_start while in LOAD is ignored.
  - WAIT_SWAP: cfg_ready=0. Waits indefinitely for swap_ok=1.
    - At the edge where swap_ok=1, active_bank toggles and the state returns to IDLE.
    - load_done=1 for exactly the following cycle.
    - cfg_start while in WAIT_SWAP is ignored.
- cfg_ready is a registered function of state and is 1 exactly while state==LOAD.
- Read port:
  - Every clk edge: rd_data <= bank[active_bank][rd_addr]. Latency is 1 cycle.
  - If rd_addr >= NUM_TAPS, rd_data <= 0.
  - Reads on the swap edge use the old bank. Reads on the next edge use the new bank.
  - The shadow bank is never visible on rd_data before the swap.
- Arithmetic: data is stored and returned bit-exact; no rounding or sign change. wr_cnt is ADDR_W bits and never exceeds NUM_TAPS-1.
- Simultaneous events:
  - swap_ok is a don't-care outside WAIT_SWAP.
  - cfg_start together with cfg_valid in IDLE: the word is not accepted, because cfg_ready is 0 that cycle.
  - load_error and load_done never assert in the same cycle.

Test Plan:
1. Reset. Pulse cfg_start. Stream 100 words of value k+1 for k=0..99 with cfg_last on the 100th. Hold swap_ok=0 for 3 cycles, then 1 -> busy stays 1 until the swap edge, active_bank=1, load_done pulses once. rd_addr=5 gives rd_data=6 one cycle later.
2. Preload bank 1 with k+1. Load a second set with values 0xFFFFFF (-1). During the load, rd_addr=5 -> rd_data stays 6 until the swap edge. On the next edge after the swap -> rd_data=-1 (24'hFFFFFF), active_bank=0.
3. Short set: cfg_last on word 50 -> load_error=1 and cfg_ready=0 on the next cycle. active_bank unchanged, no load_done. A new cfg_start clears load_error.
4. Long set: 100th word without cfg_last -> load_error=1, state IDLE, cfg_ready=0. A 101st cfg_valid is not accepted.
5. Random cfg_valid gaps across 100 words -> exactly 100 handshakes. Bank readback over addresses 0..99 matches the stimulus. rd_addr=100 or 127 -> rd_data=0.
6. Drive reset=0 for one cycle at word 40 of a load -> next cycle: busy=0, cfg_ready=0, active_bank=0, load_error=0, rd_data=0. No swap occurs even if swap_ok=1.
